// File: rtl/wb_src_arbiter.sv
// Round-robin arbiter and sequencer for the 3-input writeback source mux.
// Grants one producer, registers its word and strobes wr_en/ack for one cycle.
module wb_src_arbiter #(
    parameter int DATA_W = 32,
    parameter int N_SRC  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        req,
    input  logic              busy,
    input  logic [DATA_W-1:0] data_0,
    input  logic [DATA_W-1:0] data_1,
    input  logic [DATA_W-1:0] data_2,
    output logic [2:0]        selector,
    output logic [DATA_W-1:0] data_out,
    output logic              wr_en,
    output logic [2:0]        ack,
    output logic [1:0]        grant_idx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [2:0]        sel_d;
    logic [1:0]        gidx_d;
    logic [DATA_W-1:0] dout_d;
    logic              wr_d;
    logic [2:0]        ack_d;

    logic              hit_idle, hit_wr;
    logic [1:0]        pick_idle, pick_wr;
    logic [1:0]        ptr_nxt;
    logic [2:0]        gmask;
    logic [DATA_W-1:0] mux_word;

    // Scan r starting at p, wrapping modulo 3; returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [2:0] r,
                                           input logic [1:0] p);
        logic       found;
        logic [1:0] idx;
        int         j;
        found = 1'b0;
        idx   = 2'd0;
        for (int i = 0; i < N_SRC; i++) begin
            j = int'(p) + i;
            if (j >= N_SRC) j = j - N_SRC;
            if (!found && r[j]) begin
                found = 1'b1;
                idx   = 2'(j);
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [1:0] wrap_inc(input logic [1:0] g);
        return (g == 2'd2) ? 2'd0 : g + 2'd1;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] g);
        logic [2:0] m;
        m = 3'b000;
        m[g] = 1'b1;
        return m;
    endfunction

    assign ptr_nxt = wrap_inc(grant_idx);
    assign gmask   = onehot(grant_idx);

    // The just-acked source is masked so a lingering req is not re-served.
    assign {hit_idle, pick_idle} = rr_pick(req, ptr_q);
    assign {hit_wr, pick_wr}     = rr_pick(req & ~gmask, ptr_nxt);

    always_comb begin
        mux_word = '0;
        unique case (grant_idx)
            2'd0:    mux_word = data_0;
            2'd1:    mux_word = data_1;
            2'd2:    mux_word = data_2;
            default: mux_word = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = selector;
        gidx_d  = grant_idx;
        dout_d  = data_out;
        wr_d    = 1'b0;
        ack_d   = 3'b000;
        unique case (state_q)
            IDLE: begin
                if (hit_idle && !busy) begin
                    gidx_d  = pick_idle;
                    sel_d   = {1'b0, pick_idle};
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!req[grant_idx]) begin
                    state_d = IDLE;
                end else if (!busy) begin
                    dout_d  = mux_word;
                    wr_d    = 1'b1;
                    ack_d   = gmask;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                ptr_d = ptr_nxt;
                if (hit_wr && !busy) begin
                    gidx_d  = pick_wr;
                    sel_d   = {1'b0, pick_wr};
                    state_d = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            selector  <= 3'b000;
            grant_idx <= 2'd0;
            data_out  <= '0;
            wr_en     <= 1'b0;
            ack       <= 3'b000;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            selector  <= sel_d;
            grant_idx <= gidx_d;
            data_out  <= dout_d;
            wr_en     <= wr_d;
            ack       <= ack_d;
        end
    end

endmodule

// File: tb/tb_wb_src_arbiter.sv
// Directed bench for wb_src_arbiter: reset, single grant, round robin,
// stall, withdraw and starvation sequences with hand-computed outputs.
module tb_wb_src_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic        busy;
    logic [31:0] data_0, data_1, data_2;
    logic [2:0]  selector;
    logic [31:0] data_out;
    logic        wr_en;
    logic [2:0]  ack;
    logic [1:0]  grant_idx;

    int checks = 0;
    int failures = 0;

    wb_src_arbiter #(.DATA_W(32), .N_SRC(3)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .busy(busy),
        .data_0(data_0),
        .data_1(data_1),
        .data_2(data_2),
        .selector(selector),
        .data_out(data_out),
        .wr_en(wr_en),
        .ack(ack),
        .grant_idx(grant_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [2:0] sel,
                           input logic we, input logic [2:0] ak);
        chk({tag, ".sel"}, 32'(selector), 32'(sel));
        chk({tag, ".wr_en"}, 32'(wr_en), 32'(we));
        chk({tag, ".ack"}, 32'(ack), 32'(ak));
    endtask

    initial begin
        reset  = 1'b1;
        req    = 3'b000;
        busy   = 1'b0;
        data_0 = 32'h0A0A_0000;
        data_1 = 32'hDEAD_BEEF;
        data_2 = 32'hC2C2_2222;
        step();
        step();
        chk_out("rst", 3'b000, 1'b0, 3'b000);
        chk("rst.data_out", data_out, 32'h0);
        chk("rst.gidx", 32'(grant_idx), 32'd0);
        reset = 1'b0;

        // single request from source 1
        req = 3'b010;
        step();
        chk_out("single.grant", 3'b001, 1'b0, 3'b000);
        chk("single.gidx", 32'(grant_idx), 32'd1);
        step();
        chk_out("single.write", 3'b001, 1'b1, 3'b010);
        chk("single.data", data_out, 32'hDEAD_BEEF);
        req = 3'b000;
        step();
        chk_out("single.idle", 3'b001, 1'b0, 3'b000);
        chk("single.hold", data_out, 32'hDEAD_BEEF);

        // reset asserted in the middle of a WRITE cycle
        req = 3'b001;
        step();
        chk("rw.grant.sel", 32'(selector), 32'(3'b000));
        step();
        chk_out("rw.write", 3'b000, 1'b1, 3'b001);
        chk("rw.data", data_out, 32'h0A0A_0000);
        reset = 1'b1;
        #1;
        chk_out("rw.async", 3'b000, 1'b0, 3'b000);
        chk("rw.async.data", data_out, 32'h0);
        #1;
        reset = 1'b0;
        req   = 3'b000;
        step();
        chk_out("rw.idle", 3'b000, 1'b0, 3'b000);

        // round robin from ptr 0: order 0,1,2,0
        req = 3'b111;
        step();
        chk("rr.g0.sel", 32'(selector), 32'(3'b000));
        step();
        chk_out("rr.w0", 3'b000, 1'b1, 3'b001);
        chk("rr.w0.data", data_out, 32'h0A0A_0000);
        req = 3'b110;
        step();
        chk_out("rr.g1", 3'b001, 1'b0, 3'b000);
        req = 3'b111;
        step();
        chk_out("rr.w1", 3'b001, 1'b1, 3'b010);
        chk("rr.w1.data", data_out, 32'hDEAD_BEEF);
        req = 3'b101;
        step();
        chk_out("rr.g2", 3'b010, 1'b0, 3'b000);
        req = 3'b111;
        step();
        chk_out("rr.w2", 3'b010, 1'b1, 3'b100);
        chk("rr.w2.data", data_out, 32'hC2C2_2222);
        req = 3'b011;
        step();
        chk_out("rr.g3", 3'b000, 1'b0, 3'b000);
        req = 3'b111;
        step();
        chk_out("rr.w3", 3'b000, 1'b1, 3'b001);
        chk("rr.w3.data", data_out, 32'h0A0A_0000);
        req = 3'b000;
        step();
        chk_out("rr.idle", 3'b000, 1'b0, 3'b000);

        // stall: ptr is 1, source 0 requests, busy held 4 cycles in GRANT
        data_0 = 32'h1111_0001;
        req = 3'b001;
        step();
        chk("stall.gidx", 32'(grant_idx), 32'd0);
        busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out("stall.hold", 3'b000, 1'b0, 3'b000);
        end
        chk("stall.keep", data_out, 32'h0A0A_0000);
        busy = 1'b0;
        step();
        chk_out("stall.write", 3'b000, 1'b1, 3'b001);
        chk("stall.data", data_out, 32'h1111_0001);
        req = 3'b000;
        step();
        chk_out("stall.idle", 3'b000, 1'b0, 3'b000);

        // withdraw: ptr 1, source 2 granted then drops
        req = 3'b100;
        step();
        chk_out("wd.grant", 3'b010, 1'b0, 3'b000);
        req = 3'b000;
        step();
        chk_out("wd.abort", 3'b010, 1'b0, 3'b000);
        step();
        chk_out("wd.idle", 3'b010, 1'b0, 3'b000);
        chk("wd.data", data_out, 32'h1111_0001);
        // ptr still 1 so source 2 wins over source 0
        req = 3'b101;
        step();
        chk("wd.ptr.gidx", 32'(grant_idx), 32'd2);
        step();
        chk_out("wd.w2", 3'b010, 1'b1, 3'b100);
        req = 3'b001;
        step();
        chk_out("wd.g0", 3'b000, 1'b0, 3'b000);
        step();
        chk_out("wd.w0", 3'b000, 1'b1, 3'b001);
        chk("wd.w0.data", data_out, 32'h1111_0001);
        req = 3'b000;
        step();

        // starvation: ptr back to 0, req[0] held/re-asserted, req[2] held
        reset = 1'b1;
        #2;
        reset = 1'b0;
        req = 3'b101;
        step();
        chk("sv.g0", 32'(grant_idx), 32'd0);
        step();
        chk_out("sv.w0", 3'b000, 1'b1, 3'b001);
        step();
        chk_out("sv.g2", 3'b010, 1'b0, 3'b000);
        step();
        chk_out("sv.w2", 3'b010, 1'b1, 3'b100);
        chk("sv.w2.data", data_out, 32'hC2C2_2222);
        req = 3'b001;
        step();
        chk_out("sv.g0b", 3'b000, 1'b0, 3'b000);
        step();
        chk_out("sv.w0b", 3'b000, 1'b1, 3'b001);
        req = 3'b000;
        step();
        chk_out("sv.idle", 3'b000, 1'b0, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
